// File: rtl/fft_buf_pkg.sv
// rtl/fft_buf_pkg.sv - shared types and width helpers for the FFT write buffer
// Purpose: FSM state encoding plus pointer/count width helpers used by
//          sync_fifo and fft_write_buffer.
// Ports:   none (package)
package fft_buf_pkg;

    typedef enum logic {
        WAIT   = 1'b0,
        STREAM = 1'b1
    } fbuf_state_t;

    localparam int DEF_DATAW     = 32;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_FRAME_LEN = 8;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter must hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with synchronous clear
// Purpose: sample storage for the FFT write buffer.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clr             synchronous clear of pointers and count
//   wr_en, wr_data  write request (ignored while full)
//   rd_en, rd_data  read/pop request (ignored while empty), combinational head
//   count           current occupancy, 0..DEPTH
//   full, empty     occupancy flags
module sync_fifo
    import fft_buf_pkg::*;
#(
    parameter int DATAW = DEF_DATAW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [DATAW-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [DATAW-1:0]          rd_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A full FIFO rejects the write even when a pop happens in the same cycle.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (rst_n && !clr && wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/fft_write_buffer.sv
// rtl/fft_write_buffer.sv - frame-gathering write buffer feeding the FFT engine
// Purpose: buffers memory-stage writes and streams whole frames of FRAME_LEN
//          samples over valid/ready, marking the final sample.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 synchronous clear (keeps frames_done, overflow_err)
//   fft_wr_en_in          write request from memory stage
//   wr_data_in            sample to write
//   stall_out             buffer full, pipe must hold the write
//   out_valid, out_ready  stream handshake to FFT engine
//   out_data              sample at FIFO head
//   out_last              current sample is last of the frame
//   overflow_err          sticky: write attempted while full
//   frames_done           completed-frame counter, wraps at 2^16
module fft_write_buffer
    import fft_buf_pkg::*;
#(
    parameter int DATAW     = DEF_DATAW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             fft_wr_en_in,
    input  logic [DATAW-1:0] wr_data_in,
    output logic             stall_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_last,
    output logic             overflow_err,
    output logic [15:0]      frames_done
);

    localparam int CW = cnt_w(DEPTH);
    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);

    fbuf_state_t     state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     frames_q, frames_d;
    logic            ovf_q, ovf_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            handshake;
    logic            fifo_wr;

    // A flush drops any write presented in the same cycle.
    assign fifo_wr = fft_wr_en_in && !flush;

    sync_fifo #(
        .DATAW (DATAW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (fifo_wr),
        .wr_data (wr_data_in),
        .rd_en   (handshake),
        .rd_data (out_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign stall_out    = fifo_full;
    assign overflow_err = ovf_q;
    assign frames_done  = frames_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frames_d  = frames_q;
        ovf_d     = ovf_q;
        out_valid = (state_q == STREAM);
        out_last  = (state_q == STREAM) && (idx_q == LAST_IDX);
        handshake = out_valid && out_ready;

        if (fft_wr_en_in && fifo_full && !flush) begin
            ovf_d = 1'b1;
        end

        if (flush) begin
            state_d = WAIT;
            idx_d   = '0;
        end else begin
            case (state_q)
                WAIT: begin
                    // Entering STREAM only with a whole frame buffered means
                    // the FIFO cannot run dry before out_last.
                    if (fifo_count >= FRAME_CNT) state_d = STREAM;
                end
                STREAM: begin
                    if (handshake) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d    = '0;
                            frames_d = frames_q + 16'd1;
                            state_d  = WAIT;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= WAIT;
            idx_q    <= '0;
            frames_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            frames_q <= frames_d;
            ovf_q    <= ovf_d;
        end
    end

    logic unused_empty;
    assign unused_empty = fifo_empty;

endmodule
